// File: rtl/net_host_if.sv
// Host-side sequencer for net_proc: clears and loads one image, starts inference, returns the class.
// Optional RUN watchdog enabled by defining NET_HOST_IF_TIMEOUT_EN.
module net_host_if #(
  parameter int unsigned IMG_BYTES      = 784,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_idx,
  output logic       res_err,
  output logic       busy,
  output logic       ext_mem_rst,
  output logic       ext_mem_we,
  output logic [7:0] ext_mem_wdata,
  output logic       net_start,
  input  logic       net_done,
  input  logic [3:0] net_max_idx
);

  localparam int unsigned CW = $clog2(IMG_BYTES + 1);

  if ((IMG_BYTES < 1) || (IMG_BYTES > 945) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("net_host_if: illegal parameter values");
  end

  typedef enum logic [2:0] {IDLE, CLR, LOAD, START, RUN, RESULT} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          run_first, run_first_d;
  logic          in_ready_d, ext_mem_rst_d, ext_mem_we_d, net_start_d;
  logic          res_valid_d, res_err_d, busy_d;
  logic [7:0]    wdata_d;
  logic [3:0]    res_idx_d;
  logic          hs;

`ifdef NET_HOST_IF_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt, tcnt_d;
`endif

  assign hs = in_valid && in_ready;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    run_first_d   = 1'b0;
    in_ready_d    = 1'b0;
    ext_mem_rst_d = 1'b0;
    ext_mem_we_d  = 1'b0;
    wdata_d       = ext_mem_wdata;
    net_start_d   = 1'b0;
    res_valid_d   = res_valid;
    res_idx_d     = res_idx;
    res_err_d     = res_err;
`ifdef NET_HOST_IF_TIMEOUT_EN
    tcnt_d        = tcnt;
`endif
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_d       = CLR;
          ext_mem_rst_d = 1'b1;
          cnt_d         = '0;
        end
      end
      CLR: begin
        state_d    = LOAD;
        in_ready_d = 1'b1;
      end
      LOAD: begin
        if (hs) begin
          ext_mem_we_d = 1'b1;
          wdata_d      = in_data;
          cnt_d        = cnt + 1'b1;
        end
        // One extra LOAD cycle after the final accept lets the last write land before start.
        if (cnt == CW'(IMG_BYTES)) begin
          state_d     = START;
          net_start_d = 1'b1;
        end else begin
          in_ready_d = !(hs && (cnt == CW'(IMG_BYTES - 1)));
        end
      end
      START: begin
        state_d     = RUN;
        run_first_d = 1'b1;
`ifdef NET_HOST_IF_TIMEOUT_EN
        tcnt_d      = '0;
`endif
      end
      RUN: begin
`ifdef NET_HOST_IF_TIMEOUT_EN
        tcnt_d = tcnt + 1'b1;
`endif
        // done is stale during the first RUN cycle, so it only counts from the second on.
        if (!run_first && net_done) begin
          res_idx_d   = net_max_idx;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
`ifdef NET_HOST_IF_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          res_idx_d   = 4'hF;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      run_first     <= 1'b0;
      in_ready      <= 1'b0;
      ext_mem_rst   <= 1'b0;
      ext_mem_we    <= 1'b0;
      ext_mem_wdata <= '0;
      net_start     <= 1'b0;
      res_valid     <= 1'b0;
      res_idx       <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      run_first     <= run_first_d;
      in_ready      <= in_ready_d;
      ext_mem_rst   <= ext_mem_rst_d;
      ext_mem_we    <= ext_mem_we_d;
      ext_mem_wdata <= wdata_d;
      net_start     <= net_start_d;
      res_valid     <= res_valid_d;
      res_idx       <= res_idx_d;
      busy          <= busy_d;
    end
  end

`ifdef NET_HOST_IF_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      res_err <= 1'b0;
    end else begin
      tcnt    <= tcnt_d;
      res_err <= res_err_d;
    end
  end
`else
  logic unused_err;
  assign unused_err = res_err_d;
  assign res_err    = 1'b0;
`endif

endmodule

// File: tb/tb_net_host_if.sv
// Directed bench for net_host_if with IMG_BYTES=4; net_proc behaviour is driven by hand.
module tb_net_host_if;

  localparam int unsigned NB = 4;
`ifdef NET_HOST_IF_TIMEOUT_EN
  localparam int DLY = 12;
`else
  localparam int DLY = 20;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_idx;
  logic       res_err;
  logic       busy;
  logic       ext_mem_rst;
  logic       ext_mem_we;
  logic [7:0] ext_mem_wdata;
  logic       net_start;
  logic       net_done = 1'b0;
  logic [3:0] net_max_idx = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int clr_cnt = 0;
  int viol = 0;
  int last_we_cyc = -1;
  int start_cyc = -1;

  net_host_if #(.IMG_BYTES(NB), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_err(res_err),
    .busy(busy), .ext_mem_rst(ext_mem_rst), .ext_mem_we(ext_mem_we),
    .ext_mem_wdata(ext_mem_wdata), .net_start(net_start),
    .net_done(net_done), .net_max_idx(net_max_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write-port monitor: image captured since the most recent memory clear.
  always @(negedge clk) begin
    if (ext_mem_rst) begin
      clr_cnt++;
      wq.delete();
    end
    if (ext_mem_we) begin
      wq.push_back(ext_mem_wdata);
      last_we_cyc = cyc;
    end
    if (net_start) start_cyc = cyc;
    if ((ext_mem_we && ext_mem_rst) || (net_start && ext_mem_we)) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {in_ready, res_valid, res_idx, res_err, busy, ext_mem_rst, ext_mem_we,
            ext_mem_wdata, net_start};
  endfunction

  task automatic load_full(input logic [7:0] b [NB], input string tag);
    for (int k = 0; k < int'(NB); k++) begin
      in_valid = 1'b1;
      in_data  = b[k];
      step();
      chk({tag, "_we"}, 32'(ext_mem_we), 32'd1);
      chk({tag, "_wdata"}, 32'(ext_mem_wdata), 32'(b[k]));
    end
    in_valid = 1'b0;
    chk({tag, "_rdy_drop"}, 32'(in_ready), 32'd0);
    chk({tag, "_no_early_start"}, 32'(net_start), 32'd0);
  endtask

  task automatic check_writes(input logic [7:0] b [NB], input string tag);
    logic [7:0] obs;
    chk({tag, "_nwrites"}, 32'(wq.size()), 32'(NB));
    for (int k = 0; k < int'(NB); k++) begin
      obs = 'x;
      if (k < wq.size()) obs = wq[k];
      chk({tag, "_byte"}, 32'(obs), 32'(b[k]));
    end
  endtask

  initial begin
    logic [7:0] t1 [NB];
    logic [7:0] t2 [NB];
    logic [7:0] t3 [NB];
    logic       hs;
    int         k;
    int         n;
    int         vbad;
    t1 = '{8'h10, 8'h20, 8'h30, 8'h40};
    t2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    t3 = '{8'h01, 8'h02, 8'h03, 8'h04};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_outs", 32'(outs()), 32'd0);

    // Job 1: full-rate load, done after DLY cycles with idx 7
    in_valid = 1'b1;
    in_data  = t1[0];
    step();
    chk("j1_clr", 32'(ext_mem_rst), 32'd1);
    chk("j1_clr_rdy", 32'(in_ready), 32'd0);
    chk("j1_busy", 32'(busy), 32'd1);
    step();
    chk("j1_clr_once", 32'(ext_mem_rst), 32'd0);
    chk("j1_load_rdy", 32'(in_ready), 32'd1);
    load_full(t1, "j1");
    step();
    chk("j1_start", 32'(net_start), 32'd1);
    chk("j1_start_we", 32'(ext_mem_we), 32'd0);
    vbad = 0;
    for (int i = 0; i < DLY; i++) begin
      step();
      if (res_valid || net_start) vbad++;
    end
    chk("j1_wait_quiet", 32'(vbad), 32'd0);
    net_done    = 1'b1;
    net_max_idx = 4'd7;
    step();
    net_done = 1'b0;
    chk("j1_res_valid", 32'(res_valid), 32'd1);
    chk("j1_res_idx", 32'(res_idx), 32'd7);
    chk("j1_res_err", 32'(res_err), 32'd0);
    chk("j1_nclr", 32'(clr_cnt), 32'd1);
    check_writes(t1, "j1");
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("j1_idle_valid", 32'(res_valid), 32'd0);
    chk("j1_idle_busy", 32'(busy), 32'd0);

    // Job 2: in_valid toggling, stale done, held result
    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    step();
    k = 0;
    n = 0;
    while (k < int'(NB) && n < 20) begin
      in_valid = (n % 2 == 0);
      in_data  = t2[k];
      hs = in_valid && in_ready;
      step();
      if (hs) k++;
      n++;
    end
    in_valid = 1'b0;
    chk("j2_accepted", 32'(k), 32'(NB));
    step();
    chk("j2_start", 32'(net_start), 32'd1);
    net_done    = 1'b1;
    net_max_idx = 4'd3;
    step();
    chk("j2_start_after_write", 32'(start_cyc - last_we_cyc), 32'd1);
    step();
    net_done = 1'b0;
    chk("j2_stale_ignored", 32'(res_valid), 32'd0);
    step();
    chk("j2_low_gap", 32'(res_valid), 32'd0);
    net_done    = 1'b1;
    net_max_idx = 4'd5;
    step();
    net_done = 1'b0;
    chk("j2_res_valid", 32'(res_valid), 32'd1);
    chk("j2_res_idx", 32'(res_idx), 32'd5);
    check_writes(t2, "j2");
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_idx", 32'(res_idx), 32'd5);
      chk("hold_err", 32'(res_err), 32'd0);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("j2_idle_valid", 32'(res_valid), 32'd0);
    chk("j2_idle_busy", 32'(busy), 32'd0);
    chk("j2_idle_rdy", 32'(in_ready), 32'd0);
    step();
    chk("j3_clr_r2", 32'(ext_mem_rst), 32'd1);

    // Async reset mid-LOAD after 2 bytes
    step();
    in_data = 8'h55;
    step();
    in_data = 8'h66;
    step();
    chk("mid_we", 32'(ext_mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_outs", 32'(outs()), 32'd0);

    // Job 3: recovery after reset
    in_valid = 1'b1;
    in_data  = t3[0];
    step();
    chk("j3_clr", 32'(ext_mem_rst), 32'd1);
    step();
    chk("j3_load_rdy", 32'(in_ready), 32'd1);
    load_full(t3, "j3");
    step();
    chk("j3_start", 32'(net_start), 32'd1);
    net_done    = 1'b1;
    net_max_idx = 4'd9;
    step();
    step();
    step();
    net_done = 1'b0;
    chk("j3_res_valid", 32'(res_valid), 32'd1);
    chk("j3_res_idx", 32'(res_idx), 32'd9);
    check_writes(t3, "j3");
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("j3_idle_busy", 32'(busy), 32'd0);

`ifdef NET_HOST_IF_TIMEOUT_EN
    // Watchdog: done never comes
    in_valid = 1'b1;
    in_data  = t1[0];
    step();
    step();
    load_full(t1, "to");
    step();
    chk("to_start", 32'(net_start), 32'd1);
    repeat (16) step();
    chk("to_not_yet", 32'(res_valid), 32'd0);
    step();
    chk("to_valid", 32'(res_valid), 32'd1);
    chk("to_idx", 32'(res_idx), 32'hF);
    chk("to_err", 32'(res_err), 32'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("to_idle", 32'(busy), 32'd0);
`endif

    chk("port_overlap", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/net_host_if.md
# net_host_if

Host-side sequencer for `net_proc`: accepts one input image as a byte stream, clears and fills the processor's data memory through the external write port, and pulses `start`. It then waits for `done` and returns the predicted class index over a valid/ready result channel. It sits between the byte transport (UART/FIFO) and `net_proc`, driving the `ext_mem_*` port and consuming `done`/`max_idx_10`.

## Interface
- `IMG_BYTES`, 784: bytes per image. Legal range is 1..945 (35 chunks × 27 bytes).
- `TIMEOUT_CYCLES`, 2**20: watchdog limit in RUN. Used only with `NET_HOST_IF_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input pixel byte, passed through unmodified.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed when `res_valid && res_ready`.
- `res_idx` out 4: predicted class 0..9; 4'hF on timeout.
- `res_err` out 1: set when a timeout occurred.
- `busy` out 1: high in every state except IDLE.
- `ext_mem_rst` out 1: to `net_proc.ext_mem_rst`.
- `ext_mem_we` out 1: to `net_proc.ext_mem_we`.
- `ext_mem_wdata` out 8: to `net_proc.ext_mem_wdata`.
- `net_start` out 1: to `net_proc.start`.
- `net_done` in 1: from `net_proc.done`.
- `net_max_idx` in 4: from `net_proc.max_idx_10`.

## Operation
- All outputs are registered. Reset value of every output is 0, and state resets to IDLE.
- Byte counter width is `$clog2(IMG_BYTES+1)`. It resets to 0 on entry to CLR.
- IDLE: `in_ready`=0. When `in_valid`=1, go to CLR. No byte is consumed in this transition.
- CLR: `ext_mem_rst`=1 for exactly one cycle, then go to LOAD. This also clears `net_proc.running`.
- LOAD: `in_ready`=1.
  - Each handshake registers `ext_mem_we`=1 and `ext_mem_wdata`=`in_data` on the next cycle.
  - With no handshake, `ext_mem_we`=0 and `ext_mem_wdata` holds its value.
  - When the IMG_BYTES-th byte is accepted, `in_ready` drops in the following cycle and the state goes to START.
- START: `net_start`=1 for exactly one cycle, then go to RUN.
- RUN:
  - `net_done` is ignored in the first RUN cycle, because stale `done` from a previous inference is still high then.
  - From the second cycle on, `net_done`=1 latches `net_max_idx` into `res_idx`, clears `res_err`, and goes to RESULT.
- RESULT: `res_valid`=1. `res_idx`/`res_err` stay stable until handshake; on handshake go to IDLE with `res_valid`=0.
- Bytes arriving outside LOAD are not accepted and are held off by `in_ready`=0. Bytes of the next image may be presented during RUN/RESULT; they are accepted only after the next IDLE→CLR→LOAD sequence.
- `ext_mem_we` and `ext_mem_rst` are never high in the same cycle. `net_start` is never high while `ext_mem_we`=1.
- Reset mid-operation: all outputs go to 0 immediately and the state goes to IDLE. A partial image left in `net_proc` memory is harmless, because the next job always passes through CLR.

## Timing
- Handshake at cycle t → `ext_mem_we` high at t+1.
- Last byte accepted at cycle L → last write at L+1, `net_start` at L+2, first RUN cycle at L+3.
- `net_done` high at cycle D ≥ L+4 → `res_valid` high at D+1.
- Result handshake at cycle R → IDLE at R+1. A new CLR occurs at R+2 at the earliest, if `in_valid` is high.
- Minimum job length excluding inference: IMG_BYTES + 6 cycles at full input rate.
- Throughput: one byte per cycle in LOAD.

## Configuration
- Macro: `NET_HOST_IF_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in RUN, cleared on RUN entry.
  - When it reaches `TIMEOUT_CYCLES` without a valid `net_done`, the block sets `res_idx`=4'hF and `res_err`=1, then goes to RESULT.
  - `net_done` arriving in the same cycle as expiry wins, giving a normal result.
- Undefined: no counter. RUN waits indefinitely, `res_err` is tied 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- IMG_BYTES=4, bytes 0x10,0x20,0x30,0x40 at full rate with a model `net_proc` → `ext_mem_rst` 1 cycle, then four `ext_mem_we` pulses with those exact bytes; `net_start` at L+2; `done` after 20 cycles with idx 7 → `res_valid`, `res_idx`=7, `res_err`=0.
- `in_valid` toggling every other cycle in LOAD → exactly IMG_BYTES writes in order, no duplicates; `net_start` only after the final write.
- `net_done` held high from a previous run during `net_start` and the first RUN cycle, then low 1 cycle, then high → result is latched only on the later assertion.
- `res_ready`=0 for 10 cycles → `res_valid`, `res_idx`, and `res_err` stable throughout; `in_ready`=0 throughout; IDLE on handshake.
- `rst` asserted asynchronously mid-LOAD after 2 of 4 bytes → all outputs 0 at once; the next job performs CLR and writes all 4 bytes.
- With `NET_HOST_IF_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `net_done` never asserted → `res_valid` with `res_idx`=4'hF, `res_err`=1, 16 cycles after RUN entry.
